life_engine: RTL and testbench
==============================

// Module: life_engine
// PURPOSE
//  Computes Game-of-Life generations (B3/S23) on the fixed 20x20 grid.
//  Drives the deadOrAlive cell array read by the VGA panel display stage.
//  Works row-serially into a shadow buffer, then commits the whole buffer in one
//  cycle, so the display never sees a partially updated generation.
// PARAMETERS
//  TICK_CYCLES  50_000_000  clk cycles between auto-generations while run=1 (2 Hz @100 MHz)
//  GEN_W        16          width of the generation counter
// PORTS
//  clk          in   1          system clock; single clock domain
//  rst          in   1          asynchronous, active-high reset
//  run          in   1          level; 1 = advance one generation every TICK_CYCLES
//  step         in   1          1-cycle pulse; advance exactly one generation
//  load_valid   in   1          write load_data into row load_row of the current grid
//  load_row     in   5          row index 0..19; values 20..31 are ignored
//  load_data    in   20         row contents; bit c = column c, 1 = alive
//  load_ready   out  1          = !busy
//  busy         out  1          high in COMPUTE and COMMIT
//  deadOrAlive  out  [19:0][19:0] unpacked, indexed [row][col]; current generation
//  gen_count    out  GEN_W      committed generations since reset; wraps max->0
//  stable       out  1          last commit equalled the previous grid
//  extinct      out  1          current grid is all dead
// BEHAVIOUR
//  Reset: deadOrAlive = glider seed (alive cells at (1,2),(2,3),(3,1),(3,2),(3,3)).
//   All other cells dead. gen_count=0, stable=0, extinct=0, busy=0, state=IDLE.
//   The tick counter is cleared.
//  Tick counter: counts 0..TICK_CYCLES-1 while run=1 and pulses tick on wrap.
//   Held at 0 while run=0.
//  FSM IDLE:
//   - load_valid with load_row<20 writes the row at the next edge. Load has
//     priority: a step or tick in the same cycle is dropped.
//   - Otherwise step or tick -> COMPUTE with row_idx=0.
//  FSM COMPUTE:
//   - Each cycle, row row_idx of next_grid is set from rows row_idx-1,
//     row_idx and row_idx+1 of the current grid; row_idx increments.
//   - After row_idx=19 -> COMMIT.
//  FSM COMMIT:
//   - deadOrAlive <= next_grid; gen_count++.
//   - stable <= (next_grid==grid); extinct <= (next_grid all 0).
//   - -> IDLE.
//  Latency: the edge that samples step is E0. Busy is high E0..E21.
//   The grid, gen_count, stable and extinct update at E21.
//  Events while busy are ignored and not queued: step, tick and load_valid.
//  Rule: the neighbour count is a 4-bit value, 0..8.
//   Alive next = (n==3) | (alive & n==2).
//  Boundary: cells outside 0..19 read as dead.
//  Asynchronous rst mid-COMPUTE aborts; the shadow buffer is discarded.
// CONFIGURATION
//  LIFE_TORUS_EN defined: row and column indices wrap modulo 20, giving a toroidal grid.
//   Example: the neighbours of (0,0) include (19,19), (19,0) and (0,19).
//  LIFE_TORUS_EN undefined: dead-border boundary as above.
// STRUCTURE
//  life_pkg:
//   - GRID_N=20, ROW_W=5.
//   - typedef row_t (logic[19:0]).
//   - typedef enum {IDLE,COMPUTE,COMMIT} life_state_e.
//   - function glider_seed.
//  Sub-module life_row_eval: combinational (above,cur,below rows) -> next row.
//   It contains the 20 neighbour adders and is instantiated once.
//  life_engine holds the FSM, the tick counter, the grid and next_grid registers,
//  and the status flags.
// TESTING (TICK_CYCLES=30 in the bench)
//  1. Reset -> glider cells alive, all others dead; gen_count=0, busy=0, load_ready=1.
//  2. Clear the rows, then load a blinker at (5,4..6). Pulse step:
//     - busy for 21 cycles.
//     - Result: vertical blinker (4..6,5), gen_count=1, stable=0.
//     - A second step restores the horizontal blinker.
//  3. Block at (10..11,10..11), step -> grid unchanged, stable=1, extinct=0.
//  4. Single cell (7,7), step -> all dead, extinct=1.
//     - A further step gives stable=1 and extinct=1.
//  5. Cells (0,0),(0,1),(19,0) with step:
//     - TORUS_EN: (19,1) becomes alive.
//     - Without TORUS_EN: all die.
//  6. Robustness:
//     - step and load_valid mid-COMPUTE are ignored.
//     - run=1 gives one generation per 30 cycles.
//     - rst asserted at row_idx=10 restores the glider, gen_count=0.

Source files
------------

// File: rtl/life_pkg.sv
// -----------------------------------------------------------------------------
// life_pkg
//  Shared definitions for the Game-of-Life engine.
//  - GRID_N / ROW_W : grid edge length and the width of a row index
//  - row_t          : one grid row, bit c = column c, 1 = alive
//  - life_state_e   : engine FSM states
//  - glider_seed    : reset contents of a given row (glider pattern)
// -----------------------------------------------------------------------------
package life_pkg;

    localparam int GRID_N = 20;
    localparam int ROW_W  = 5;

    typedef logic [GRID_N-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMMIT  = 2'd2
    } life_state_e;

    // Glider: (1,2), (2,3), (3,1), (3,2), (3,3); every other cell dead.
    function automatic row_t glider_seed(input logic [ROW_W-1:0] row);
        row_t r;
        r = '0;
        case (row)
            5'd1:    r[2]   = 1'b1;
            5'd2:    r[3]   = 1'b1;
            5'd3:    r[3:1] = 3'b111;
            default: r      = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/life_row_eval.sv
// -----------------------------------------------------------------------------
// life_row_eval
//  Combinational B3/S23 evaluation of one grid row.
//  Ports:
//   above    in  20  row r-1 (already resolved for the row boundary by caller)
//   cur      in  20  row r
//   below    in  20  row r+1 (already resolved for the row boundary by caller)
//   next_row out 20  row r of the next generation
//  Configuration: LIFE_TORUS_EN defined -> columns wrap modulo 20;
//  otherwise columns outside 0..19 read as dead.
// -----------------------------------------------------------------------------
module life_row_eval
    import life_pkg::*;
(
    input  logic [GRID_N-1:0] above,
    input  logic [GRID_N-1:0] cur,
    input  logic [GRID_N-1:0] below,
    output logic [GRID_N-1:0] next_row
);

    // Each row is padded by one column on both sides: bit 0 of the extended
    // vector is column -1, bit GRID_N+1 is column GRID_N. Column c of the grid
    // then sits at extended bit c+1, so its three-wide window is [c +: 3].
    logic [GRID_N+1:0] a_ext;
    logic [GRID_N+1:0] m_ext;
    logic [GRID_N+1:0] b_ext;

`ifdef LIFE_TORUS_EN
    assign a_ext = {above[0], above, above[GRID_N-1]};
    assign m_ext = {cur[0],   cur,   cur[GRID_N-1]};
    assign b_ext = {below[0], below, below[GRID_N-1]};
`else
    assign a_ext = {1'b0, above, 1'b0};
    assign m_ext = {1'b0, cur,   1'b0};
    assign b_ext = {1'b0, below, 1'b0};
`endif

    for (genvar c = 0; c < GRID_N; c++) begin : g_col
        logic [3:0] n;

        // Eight neighbours; the centre (m_ext[c+1]) is deliberately excluded.
        assign n = 4'(a_ext[c]) + 4'(a_ext[c+1]) + 4'(a_ext[c+2])
                 + 4'(m_ext[c])                  + 4'(m_ext[c+2])
                 + 4'(b_ext[c]) + 4'(b_ext[c+1]) + 4'(b_ext[c+2]);

        assign next_row[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
    end

endmodule

// File: rtl/life_engine.sv
// -----------------------------------------------------------------------------
// life_engine
//  Game-of-Life (B3/S23) generation engine on a fixed 20x20 grid.
//  Rows of the next generation are computed one per cycle into a shadow
//  buffer, then the whole buffer replaces the visible grid in a single cycle,
//  so deadOrAlive never shows a half-updated generation.
//
//  Parameters:
//   TICK_CYCLES  clk cycles between automatic generations while run=1
//   GEN_W        width of the generation counter
//  Ports:
//   clk, rst     clock; asynchronous active-high reset
//   run          level: advance one generation every TICK_CYCLES cycles
//   step         1-cycle pulse: advance exactly one generation
//   load_valid   write load_data into row load_row (ignored when row >= 20)
//   load_row     row index
//   load_data    row contents, bit c = column c
//   load_ready   = !busy
//   busy         high while a generation is being computed or committed
//   deadOrAlive  current generation, indexed [row][col]
//   gen_count    committed generations since reset (wraps)
//   stable       last commit left the grid unchanged
//   extinct      current grid is all dead
//
//  Handshake: load_valid/step/tick are only acted on in IDLE (load_ready=1).
//  A request presented while busy is dropped, never queued. In IDLE a valid
//  load wins over a step or tick in the same cycle; the step/tick is dropped.
//
//  Configuration macro: LIFE_TORUS_EN -> rows and columns wrap modulo 20.
// -----------------------------------------------------------------------------
module life_engine
    import life_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int GEN_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              step,
    input  logic              load_valid,
    input  logic [ROW_W-1:0]  load_row,
    input  logic [GRID_N-1:0] load_data,
    output logic              load_ready,
    output logic              busy,
    output logic [GRID_N-1:0] deadOrAlive [GRID_N],
    output logic [GEN_W-1:0]  gen_count,
    output logic              stable,
    output logic              extinct
);

    localparam int                CNT_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  TICK_LAST = CNT_W'(TICK_CYCLES - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(GRID_N - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROW_LIMIT = ROW_W'(GRID_N);

    life_state_e       state_q,   state_d;
    logic [ROW_W-1:0]  row_idx_q, row_idx_d;
    logic [CNT_W-1:0]  cnt_q,     cnt_d;
    row_t              grid_q      [GRID_N];
    row_t              grid_d      [GRID_N];
    row_t              next_grid_q [GRID_N];
    row_t              next_grid_d [GRID_N];
    logic [GEN_W-1:0]  gen_q,     gen_d;
    logic              stable_q,  stable_d;
    logic              extinct_q, extinct_d;

    logic              tick;
    row_t              row_above;
    row_t              row_cur;
    row_t              row_below;
    row_t              row_new;
    logic              grid_same;
    logic              grid_dead;

    // ------------------------------------------------------------------
    // Tick counter: free-runs 0..TICK_CYCLES-1 while run=1, parked at 0
    // otherwise. It keeps counting while busy; a tick that lands while busy
    // is simply lost.
    // ------------------------------------------------------------------
    assign tick = run && (cnt_q == TICK_LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == TICK_LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Neighbour-row selection for the row being computed. Rows outside the
    // grid are dead unless the torus build wraps them around.
    // ------------------------------------------------------------------
    assign row_cur = grid_q[row_idx_q];

    always_comb begin
        row_above = '0;
        row_below = '0;
        if (row_idx_q != '0) begin
            row_above = grid_q[row_idx_q - ROW_ONE];
        end else begin
`ifdef LIFE_TORUS_EN
            row_above = grid_q[LAST_ROW];
`else
            row_above = '0;
`endif
        end
        if (row_idx_q != LAST_ROW) begin
            row_below = grid_q[row_idx_q + ROW_ONE];
        end else begin
`ifdef LIFE_TORUS_EN
            row_below = grid_q[0];
`else
            row_below = '0;
`endif
        end
    end

    life_row_eval u_row_eval (
        .above    (row_above),
        .cur      (row_cur),
        .below    (row_below),
        .next_row (row_new)
    );

    // Status of the finished shadow buffer, consumed in COMMIT.
    always_comb begin
        grid_same = 1'b1;
        grid_dead = 1'b1;
        for (int r = 0; r < GRID_N; r++) begin
            if (next_grid_q[r] != grid_q[r]) grid_same = 1'b0;
            if (next_grid_q[r] != '0)        grid_dead = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // FSM next-state and datapath updates
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        row_idx_d   = row_idx_q;
        grid_d      = grid_q;
        next_grid_d = next_grid_q;
        gen_d       = gen_q;
        stable_d    = stable_q;
        extinct_d   = extinct_q;

        case (state_q)
            IDLE: begin
                if (load_valid && (load_row < ROW_LIMIT)) begin
                    grid_d[load_row] = load_data;
                end else if (step || tick) begin
                    state_d   = COMPUTE;
                    row_idx_d = '0;
                end
            end

            COMPUTE: begin
                next_grid_d[row_idx_q] = row_new;
                if (row_idx_q == LAST_ROW) begin
                    state_d = COMMIT;
                end else begin
                    row_idx_d = row_idx_q + ROW_ONE;
                end
            end

            COMMIT: begin
                grid_d    = next_grid_q;
                gen_d     = gen_q + GEN_W'(1);
                stable_d  = grid_same;
                extinct_d = grid_dead;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State registers. Reset mid-COMPUTE throws away the shadow buffer.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            row_idx_q <= '0;
            cnt_q     <= '0;
            gen_q     <= '0;
            stable_q  <= 1'b0;
            extinct_q <= 1'b0;
            for (int r = 0; r < GRID_N; r++) begin
                grid_q[r]      <= glider_seed(ROW_W'(r));
                next_grid_q[r] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_idx_q   <= row_idx_d;
            cnt_q       <= cnt_d;
            gen_q       <= gen_d;
            stable_q    <= stable_d;
            extinct_q   <= extinct_d;
            grid_q      <= grid_d;
            next_grid_q <= next_grid_d;
        end
    end

    assign busy        = (state_q != IDLE);
    assign load_ready  = !busy;
    assign deadOrAlive = grid_q;
    assign gen_count   = gen_q;
    assign stable      = stable_q;
    assign extinct     = extinct_q;

endmodule

// File: tb/tb_life_engine.sv
module tb_life_engine;

    localparam int TICK = 30;
    localparam int N    = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run = 1'b0;
    logic        step = 1'b0;
    logic        load_valid = 1'b0;
    logic [4:0]  load_row = '0;
    logic [19:0] load_data = '0;
    logic        load_ready;
    logic        busy;
    logic [19:0] doa [N];
    logic [15:0] gen_count;
    logic        stable;
    logic        extinct;

    int tests = 0;
    int fails = 0;
    logic chk_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    life_engine #(.TICK_CYCLES(TICK), .GEN_W(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .load_valid  (load_valid),
        .load_row    (load_row),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .busy        (busy),
        .deadOrAlive (doa),
        .gen_count   (gen_count),
        .stable      (stable),
        .extinct     (extinct)
    );

    // ---------------- behavioural model ----------------
    logic [19:0] m_grid [N];
    logic [19:0] m_next [N];
    logic [15:0] m_gen;
    logic        m_stable;
    logic        m_extinct;
    int          m_busy_left;   // cycles of busy still to come; commit when it hits 0
    int          m_tick_cnt;
    logic        m_tick;

    function automatic void compute_next();
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                int n;
                n = 0;
                for (int dr = -1; dr <= 1; dr++) begin
                    for (int dc = -1; dc <= 1; dc++) begin
                        int rr;
                        int cc;
                        if (dr == 0 && dc == 0) continue;
                        rr = r + dr;
                        cc = c + dc;
`ifdef LIFE_TORUS_EN
                        rr = (rr + N) % N;
                        cc = (cc + N) % N;
`else
                        if (rr < 0 || rr >= N || cc < 0 || cc >= N) continue;
`endif
                        n += int'(m_grid[rr][cc]);
                    end
                end
                m_next[r][c] = (n == 3) || (m_grid[r][c] && n == 2);
            end
        end
    endfunction

    function automatic void model_reset();
        for (int r = 0; r < N; r++) m_grid[r] = 20'h0;
        m_grid[1]   = 20'h00004;
        m_grid[2]   = 20'h00008;
        m_grid[3]   = 20'h0000E;
        m_gen       = '0;
        m_stable    = 1'b0;
        m_extinct   = 1'b0;
        m_busy_left = 0;
        m_tick_cnt  = 0;
    endfunction

    function automatic void model_commit();
        logic same;
        logic dead;
        compute_next();
        same = 1'b1;
        dead = 1'b1;
        for (int r = 0; r < N; r++) begin
            if (m_next[r] != m_grid[r]) same = 1'b0;
            if (m_next[r] != 20'h0)     dead = 1'b0;
        end
        for (int r = 0; r < N; r++) m_grid[r] = m_next[r];
        m_gen     = m_gen + 16'd1;
        m_stable  = same;
        m_extinct = dead;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            model_reset();
        end else begin
            m_tick     = run && (m_tick_cnt == TICK - 1);
            m_tick_cnt = (!run || m_tick_cnt == TICK - 1) ? 0 : m_tick_cnt + 1;
            if (m_busy_left > 0) begin
                m_busy_left--;
                if (m_busy_left == 0) model_commit();
            end else if (load_valid && load_row < 5'd20) begin
                m_grid[load_row] = load_data;
            end else if (step || m_tick) begin
                m_busy_left = 21;
            end
        end
    end

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            int bad;
            bad = -1;
            for (int r = 0; r < N; r++)
                if (bad < 0 && doa[r] !== m_grid[r]) bad = r;
            tests++;
            if (bad >= 0) begin
                fails++;
                $display("FAIL grid row %0d: got %05h expected %05h at %0t",
                         bad, doa[bad], m_grid[bad], $time);
            end
            chk("busy",       32'(busy),       32'(m_busy_left > 0));
            chk("load_ready", 32'(load_ready), 32'(m_busy_left == 0));
            chk("gen_count",  32'(gen_count),  32'(m_gen));
            chk("stable",     32'(stable),     32'(m_stable));
            chk("extinct",    32'(extinct),    32'(m_extinct));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic load(input logic [4:0] r, input logic [19:0] d);
        load_valid = 1'b1;
        load_row   = r;
        load_data  = d;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic clear_grid();
        for (int r = 0; r < N; r++) load(5'(r), 20'h0);
    endtask

    task automatic pulse_step();
        step = 1'b1;
        cyc();
        step = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            n++;
            cyc();
        end
        tests++;
        if (n >= 200) begin
            fails++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, n);
        end
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int n;
        logic [15:0] g0;
        logic [15:0] gexp;

        rst = 1'b1;
        repeat (3) cyc();
        rst = 1'b0;
        chk_en = 1'b1;

        // 1. reset state
        chk("rst_row0", 32'(doa[0]), 32'h0);
        chk("rst_row1", 32'(doa[1]), 32'h00004);
        chk("rst_row2", 32'(doa[2]), 32'h00008);
        chk("rst_row3", 32'(doa[3]), 32'h0000E);
        chk("rst_row19", 32'(doa[19]), 32'h0);
        chk("rst_gen", 32'(gen_count), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_load_ready", 32'(load_ready), 32'h1);
        chk("model_rst_row3", 32'(m_grid[3]), 32'h0000E);

        // 2. blinker
        clear_grid();
        load(5'd5, 20'h00070);
        pulse_step();
        n = 0;
        while (busy && n < 100) begin
            n++;
            cyc();
        end
        chk("busy_len", 32'(n), 32'd21);
        chk("blink_v_row4", 32'(doa[4]), 32'h00020);
        chk("blink_v_row5", 32'(doa[5]), 32'h00020);
        chk("blink_v_row6", 32'(doa[6]), 32'h00020);
        chk("blink_v_row3", 32'(doa[3]), 32'h0);
        chk("blink_gen1", 32'(gen_count), 32'd1);
        chk("blink_stable0", 32'(stable), 32'h0);
        chk("model_blink_row4", 32'(m_grid[4]), 32'h00020);
        pulse_step();
        wait_idle();
        chk("blink_h_row5", 32'(doa[5]), 32'h00070);
        chk("blink_h_row4", 32'(doa[4]), 32'h0);
        chk("blink_gen2", 32'(gen_count), 32'd2);

        // 3. block still life
        load(5'd5, 20'h0);
        load(5'd10, 20'h00C00);
        load(5'd11, 20'h00C00);
        pulse_step();
        wait_idle();
        chk("block_row10", 32'(doa[10]), 32'h00C00);
        chk("block_row11", 32'(doa[11]), 32'h00C00);
        chk("block_stable", 32'(stable), 32'h1);
        chk("block_extinct", 32'(extinct), 32'h0);

        // 4. lone cell dies
        load(5'd10, 20'h0);
        load(5'd11, 20'h0);
        load(5'd7, 20'h00080);
        pulse_step();
        wait_idle();
        chk("single_row7", 32'(doa[7]), 32'h0);
        chk("single_extinct", 32'(extinct), 32'h1);
        chk("single_stable0", 32'(stable), 32'h0);
        pulse_step();
        wait_idle();
        chk("dead_stable", 32'(stable), 32'h1);
        chk("dead_extinct", 32'(extinct), 32'h1);

        // 5. corner cells, boundary behaviour
        load(5'd0, 20'h00003);
        load(5'd19, 20'h00001);
        pulse_step();
        wait_idle();
`ifdef LIFE_TORUS_EN
        chk("torus_19_1", 32'(doa[19][1]), 32'h1);
        chk("torus_extinct", 32'(extinct), 32'h0);
`else
        chk("border_row0", 32'(doa[0]), 32'h0);
        chk("border_row19", 32'(doa[19]), 32'h0);
        chk("border_extinct", 32'(extinct), 32'h1);
`endif

        // 6a. step and load while busy are dropped
        clear_grid();
        load(5'd5, 20'h00070);
        g0 = gen_count;
        pulse_step();
        repeat (4) cyc();
        step       = 1'b1;
        load_valid = 1'b1;
        load_row   = 5'd0;
        load_data  = 20'hFFFFF;
        cyc();
        step       = 1'b0;
        load_valid = 1'b0;
        wait_idle();
        gexp = g0 + 16'd1;
        chk("ignored_gen", 32'(gen_count), 32'(gexp));
        chk("ignored_row0", 32'(doa[0]), 32'h0);
        chk("ignored_row4", 32'(doa[4]), 32'h00020);
        cyc();
        chk("not_queued", 32'(busy), 32'h0);

        // 6b. run: one generation per TICK cycles
        g0 = gen_count;
        run = 1'b1;
        repeat (115) cyc();
        run = 1'b0;
        wait_idle();
        gexp = g0 + 16'd3;
        chk("run_gens", 32'(gen_count), 32'(gexp));

        // 6c. reset in the middle of COMPUTE (row_idx = 10)
        pulse_step();
        repeat (10) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("midrst_row1", 32'(doa[1]), 32'h00004);
        chk("midrst_row3", 32'(doa[3]), 32'h0000E);
        chk("midrst_row5", 32'(doa[5]), 32'h0);
        chk("midrst_gen", 32'(gen_count), 32'h0);
        chk("midrst_busy", 32'(busy), 32'h0);

        // Random phase, checked per cycle against the model.
        for (int it = 0; it < 40; it++) begin
            int k;
            int mode;
            k = $urandom_range(0, 4);
            for (int j = 0; j < k; j++) begin
                logic [31:0] ra;
                logic [31:0] rb;
                ra = $urandom();
                rb = $urandom();
                load(5'($urandom_range(0, 19)), ra[19:0] & rb[19:0]);
            end
            if ($urandom_range(0, 3) == 0) load(5'($urandom_range(20, 31)), 20'hFFFFF);
            mode = $urandom_range(0, 3);
            case (mode)
                0: begin
                    pulse_step();
                    repeat ($urandom_range(1, 18)) cyc();
                    step       = 1'($urandom_range(0, 1));
                    load_valid = 1'($urandom_range(0, 1));
                    load_row   = 5'($urandom_range(0, 19));
                    load_data  = 20'($urandom());
                    cyc();
                    step       = 1'b0;
                    load_valid = 1'b0;
                    wait_idle();
                end
                1: begin
                    run = 1'b1;
                    repeat ($urandom_range(30, 100)) cyc();
                    run = 1'b0;
                    wait_idle();
                end
                2: begin
                    step       = 1'b1;
                    load_valid = 1'b1;
                    load_row   = 5'($urandom_range(0, 19));
                    load_data  = 20'($urandom());
                    cyc();
                    step       = 1'b0;
                    load_valid = 1'b0;
                    cyc();
                end
                default: begin
                    pulse_step();
                    wait_idle();
                end
            endcase
        end

        repeat (2) cyc();
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
